// File: rtl/approx_mult_err_sweep_pkg.sv
// Shared types and width helpers for the approximate-multiplier error sweep.
package approx_mult_err_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DIVIDE,
    ST_ACCUM,
    ST_DONE
  } state_e;

  localparam int unsigned SCALE_DEF = 10000;
  // Extra dividend bits needed to hold ed*SCALE for SCALE up to 2^14.
  localparam int unsigned DIV_EXTRA = 14;

  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned dvd_w(input int unsigned w);
    return 2 * w + DIV_EXTRA;
  endfunction

endpackage

// File: rtl/approx_mult_err_sweep_seq_div.sv
// Restoring serial divider; quotient and one-cycle done arrive NW cycles after start.
module seq_div #(
  parameter int unsigned NW = 22,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient,
  output logic          done
);

  localparam int unsigned CW = $clog2(NW + 1);

  logic [DW-1:0] rem_q, rem_d, dvs_q, dvs_d, rem_in, dvs_in;
  logic [NW-1:0] quot_q, quot_d, q_in;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [DW:0]   trial_c;

  // The start cycle performs the first step itself so the latency is exactly NW.
  always_comb begin
    rem_in  = start ? '0 : rem_q;
    q_in    = start ? dividend : quot_q;
    dvs_in  = start ? divisor : dvs_q;
    trial_c = {rem_in, q_in[NW-1]};
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start || (cnt_q != '0)) begin
      dvs_d = dvs_in;
      if (trial_c >= {1'b0, dvs_in}) begin
        rem_d  = DW'(trial_c - {1'b0, dvs_in});
        quot_d = {q_in[NW-2:0], 1'b1};
      end else begin
        rem_d  = trial_c[DW-1:0];
        quot_d = {q_in[NW-2:0], 1'b0};
      end
      if (start) begin
        cnt_d = CW'(NW - 1);
      end else begin
        cnt_d  = cnt_q - CW'(1);
        done_d = (cnt_q == CW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = quot_q;
  assign done     = done_q;

endmodule

// File: rtl/approx_mult_err_sweep.sv
// Sweeps all nonzero operand pairs through an external multiplier and accumulates error metrics.
module approx_mult_err_sweep
  import approx_mult_err_sweep_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned SCALE = SCALE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     mult_a,
  output logic [W-1:0]     mult_b,
  input  logic [2*W-1:0]   mult_r,
  output logic [15:0]      err_count,
  output logic [31:0]      err_dist_sum,
  output logic [2*W-1:0]   max_err,
  output logic [31:0]      red_sum
);

  localparam int unsigned PW = prod_w(W);
  localparam int unsigned NW = dvd_w(W);
  localparam logic [W-1:0] MAXV = '1;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0] r_q, r_d, ed_q, ed_d, max_q, max_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   dsum_q, dsum_d, rsum_q, rsum_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [PW-1:0] exact_c, ed_c;
  logic [NW-1:0] div_q;
  logic          div_start_c, div_done, last_c;

  assign exact_c = PW'(a_q) * PW'(b_q);
  assign ed_c    = (r_q >= exact_c) ? (r_q - exact_c) : (exact_c - r_q);
  assign last_c  = (a_q == MAXV) && (b_q == MAXV);

  seq_div #(.NW(NW), .DW(PW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend (NW'(ed_c) * NW'(SCALE)),
    .divisor  (exact_c),
    .quotient (div_q),
    .done     (div_done)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    ed_d        = ed_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    dsum_d      = dsum_q;
    rsum_d      = rsum_q;
    busy_d      = busy_q;
    done_d      = done_q;
    div_start_c = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = W'(1);
          b_d     = W'(1);
          max_d   = '0;
          cnt_d   = '0;
          dsum_d  = '0;
          rsum_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        r_d     = mult_r;
        state_d = ST_CHECK;
      end
      ST_CHECK, ST_ACCUM: begin
        if (state_q == ST_CHECK && ed_c != '0) begin
          div_start_c = 1'b1;
          ed_d        = ed_c;
          state_d     = ST_DIVIDE;
        end else begin
          if (state_q == ST_ACCUM) begin
            cnt_d  = cnt_q + 16'd1;
            dsum_d = dsum_q + 32'(ed_q);
            rsum_d = rsum_q + 32'(div_q);
            if (ed_q > max_q) max_d = ed_q;
          end
          if (last_c) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            // b is the inner loop and wraps to 1, never to 0.
            b_d     = (b_q == MAXV) ? W'(1) : b_q + W'(1);
            a_d     = (b_q == MAXV) ? a_q + W'(1) : a_q;
            state_d = ST_APPLY;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) state_d = ST_ACCUM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      ed_q    <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      dsum_q  <= '0;
      rsum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      ed_q    <= ed_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      dsum_q  <= dsum_d;
      rsum_q  <= rsum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mult_a       = a_q;
  assign mult_b       = b_q;
  assign err_count    = cnt_q;
  assign err_dist_sum = dsum_q;
  assign max_err      = max_q;
  assign red_sum      = rsum_q;

endmodule

// File: tb/tb_approx_mult_err_sweep.sv
// Randomized self-checking bench with a stubbed multiplier and an arithmetic reference model.
module tb_approx_mult_err_sweep;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        busy, done;
  logic [3:0]  mult_a, mult_b;
  logic [7:0]  mult_r;
  logic [15:0] err_count;
  logic [31:0] err_dist_sum, red_sum;
  logic [7:0]  max_err;

  bit         stub_en  [16][16];
  logic [7:0] stub_val [16][16];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         mon_idx = 0;
  int         mon_base;
  bit         mon_en;
  logic [7:0] mon_prev;

  approx_mult_err_sweep #(.W(4), .SCALE(10000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_r       (mult_r),
    .err_count    (err_count),
    .err_dist_sum (err_dist_sum),
    .max_err      (max_err),
    .red_sum      (red_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mult_r = stub_en[mult_a][mult_b] ? stub_val[mult_a][mult_b]
                                          : ({4'b0, mult_a} * {4'b0, mult_b});

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every operand change while busy must be the next pair of the row-major 1..15 sweep.
  always @(negedge clk) begin
    if (mon_en && busy && ({mult_a, mult_b} != mon_prev)) begin
      chk("pair_order", {mult_a, mult_b},
          ((mon_idx - mon_base) / 15 + 1) * 16 + ((mon_idx - mon_base) % 15 + 1));
      mon_idx <= mon_idx + 1;
    end
    mon_prev <= {mult_a, mult_b};
  end

  task automatic clear_stub();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        stub_en[a][b]  = 1'b0;
        stub_val[a][b] = 8'd0;
      end
  endtask

  task automatic model(output int unsigned e_cnt, output int unsigned e_dsum,
                       output int unsigned e_max, output int unsigned e_rsum,
                       output int unsigned e_cyc);
    int unsigned exact, r, ed;
    e_cnt = 0; e_dsum = 0; e_max = 0; e_rsum = 0; e_cyc = 0;
    for (int a = 1; a <= 15; a++)
      for (int b = 1; b <= 15; b++) begin
        exact = a * b;
        r     = stub_en[a][b] ? int'(stub_val[a][b]) : exact;
        ed    = (r > exact) ? r - exact : exact - r;
        if (ed == 0) begin
          e_cyc += 2;
        end else begin
          e_cyc  += 25;
          e_cnt  += 1;
          e_dsum += ed;
          e_rsum += (ed * 10000) / exact;
          if (ed > e_max) e_max = ed;
        end
      end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_a"}, mult_a, 0);
    chk({tag, "_b"}, mult_b, 0);
    chk({tag, "_cnt"}, err_count, 0);
    chk({tag, "_dsum"}, err_dist_sum, 0);
    chk({tag, "_max"}, max_err, 0);
    chk({tag, "_rsum"}, red_sum, 0);
  endtask

  task automatic run_sweep(input string tag, input bit repulse);
    int unsigned e_cnt, e_dsum, e_max, e_rsum, e_cyc;
    int s, d;
    bit got;
    model(e_cnt, e_dsum, e_max, e_rsum, e_cyc);
    mon_base = mon_idx;
    mon_en   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_cnt_clr"}, err_count, 0);
    chk({tag, "_dsum_clr"}, err_dist_sum, 0);
    chk({tag, "_rsum_clr"}, red_sum, 0);
    got = 1'b0;
    d   = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        got = 1'b1;
        d   = cyc;
        break;
      end
      @(negedge clk);
      start = repulse && (i == 3 || i == 60 || i == 71);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_done_cycle"}, d - s, e_cyc + 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_cnt"}, err_count, e_cnt);
    chk({tag, "_dsum"}, err_dist_sum, e_dsum);
    chk({tag, "_max"}, max_err, e_max);
    chk({tag, "_rsum"}, red_sum, e_rsum);
    chk({tag, "_pairs"}, mon_idx - mon_base, 225);
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_hold_done"}, done, 1);
    chk({tag, "_hold_cnt"}, err_count, e_cnt);
    chk({tag, "_hold_rsum"}, red_sum, e_rsum);
    chk({tag, "_hold_a"}, mult_a, 15);
    chk({tag, "_hold_b"}, mult_b, 15);
  endtask

  initial begin
    bit seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    mon_en = 1'b0;
    clear_stub();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run_sweep("exact", 1'b0);

    clear_stub();
    stub_en[3][5]  = 1'b1;
    stub_val[3][5] = 8'd0;
    run_sweep("zero35_repulse", 1'b1);
    run_sweep("zero35_restart", 1'b0);

    clear_stub();
    stub_en[15][15]  = 1'b1;
    stub_val[15][15] = 8'd255;
    run_sweep("over1515", 1'b0);

    // Reset while the divider is working on pair (3,5).
    clear_stub();
    stub_en[3][5]  = 1'b1;
    stub_val[3][5] = 8'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (mult_a == 4'd3 && mult_b == 4'd5) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("middiv_reach", seen, 1);
    repeat (4) @(negedge clk);
    chk("middiv_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("middiv_rst");
    rst_n = 1'b1;
    run_sweep("after_rst", 1'b0);

    for (int k = 0; k < 3; k++) begin
      int nf;
      clear_stub();
      nf = $urandom_range(1, 12);
      for (int j = 0; j < nf; j++) begin
        int a, b;
        a = $urandom_range(1, 15);
        b = $urandom_range(1, 15);
        stub_en[a][b]  = 1'b1;
        stub_val[a][b] = 8'($urandom_range(0, 255));
      end
      run_sweep($sformatf("rand%0d", k), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
